// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL reset sequencer and its synchronizer.
package pll_seq_pkg;

   localparam int unsigned PLL_SEQ_CNT_W  = 16;
   localparam int unsigned PLL_SEQ_LOSS_W = 8;

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } pll_seq_state_t;

endpackage

// File: rtl/lock_sync.sv
// Generic 2-flop synchronizer with synchronous reset to 0, for PLL status bits.
import pll_seq_pkg::*;

module lock_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Power-up / lock-loss sequencer for the PLL, running on the raw oscillator clock.
// Define PLL_SEQ_RELOCK_EN to re-sequence automatically after lock loss in RUN instead of failing.
import pll_seq_pkg::*;

module pll_reset_sequencer #(
   parameter int unsigned PLL_RST_CYCLES      = 27,
   parameter int unsigned LOCK_STABLE_CYCLES  = 2700,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 27000,
   parameter int unsigned MAX_RETRIES         = 3
) (
   input  logic                      clkin,
   input  logic                      reset,
   input  logic                      pll_lock,
   input  logic                      soft_req,
   output logic                      pll_reset,
   output logic                      sys_reset,
   output logic                      ready,
   output logic                      fail,
   output logic [1:0]                retry_cnt,
   output logic [PLL_SEQ_LOSS_W-1:0] loss_cnt
);

   if (PLL_RST_CYCLES == 0 || PLL_RST_CYCLES > 65535 ||
       LOCK_STABLE_CYCLES == 0 || LOCK_STABLE_CYCLES > 65535 ||
       LOCK_TIMEOUT_CYCLES == 0 || LOCK_TIMEOUT_CYCLES > 65535 ||
       MAX_RETRIES > 3) begin : g_bad_params
      $error("pll_reset_sequencer: cycle parameters must be 1..65535 and MAX_RETRIES <= 3");
   end

   localparam logic [PLL_SEQ_CNT_W-1:0] RST_LAST = PLL_SEQ_CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [PLL_SEQ_CNT_W-1:0] STB_LAST = PLL_SEQ_CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [PLL_SEQ_CNT_W-1:0] TMO_LAST = PLL_SEQ_CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [1:0]               RETRY_MAX = 2'(MAX_RETRIES);

   pll_seq_state_t            state, state_n;
   logic [PLL_SEQ_CNT_W-1:0]  cnt, cnt_n;
   logic [1:0]                retry_n;
   logic [PLL_SEQ_LOSS_W-1:0] loss_n;
   logic                      lock_s;

   lock_sync u_lock_sync (
      .clk   (clkin),
      .reset (reset),
      .d     (pll_lock),
      .q     (lock_s)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt + PLL_SEQ_CNT_W'(1);
      retry_n = retry_cnt;
      loss_n  = loss_cnt;
      if (soft_req) begin
         state_n = ST_PLL_RST;
         cnt_n   = '0;
         retry_n = '0;
      end else begin
         case (state)
            ST_PLL_RST: begin
               if (cnt == RST_LAST) begin
                  state_n = ST_WAIT_LOCK;
                  cnt_n   = '0;
               end
            end
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  state_n = ST_STABLE;
                  cnt_n   = '0;
               end else if (cnt == TMO_LAST) begin
                  cnt_n = '0;
                  if (retry_cnt == RETRY_MAX) begin
                     state_n = ST_FAIL;
                  end else begin
                     retry_n = retry_cnt + 2'd1;
                     state_n = ST_PLL_RST;
                  end
               end
            end
            ST_STABLE: begin
               // Any dropout restarts both the stable window and the lock timeout.
               if (!lock_s) begin
                  state_n = ST_WAIT_LOCK;
                  cnt_n   = '0;
               end else if (cnt == STB_LAST) begin
                  state_n = ST_RUN;
                  cnt_n   = '0;
               end
            end
            ST_RUN: begin
               cnt_n = '0;
               if (!lock_s) begin
                  if (loss_cnt != '1) loss_n = loss_cnt + PLL_SEQ_LOSS_W'(1);
`ifdef PLL_SEQ_RELOCK_EN
                  state_n = ST_PLL_RST;
                  retry_n = '0;
`else
                  state_n = ST_FAIL;
`endif
               end
            end
            ST_FAIL: cnt_n = '0;
            default: begin
               state_n = ST_PLL_RST;
               cnt_n   = '0;
            end
         endcase
      end
   end

   // Outputs decode the next state so they switch on the same edge as the state.
   always_ff @(posedge clkin) begin
      if (reset) begin
         state     <= ST_PLL_RST;
         cnt       <= '0;
         retry_cnt <= '0;
         loss_cnt  <= '0;
         pll_reset <= 1'b1;
         sys_reset <= 1'b1;
         ready     <= 1'b0;
         fail      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         retry_cnt <= retry_n;
         loss_cnt  <= loss_n;
         pll_reset <= (state_n == ST_PLL_RST) || (state_n == ST_FAIL);
         sys_reset <= (state_n != ST_RUN);
         ready     <= (state_n == ST_RUN);
         fail      <= (state_n == ST_FAIL);
      end
   end

endmodule
